cp0_reg: RTL

- Coprocessor-0 register file; the consumer end of the writeback-stage CP0 write interface (wb_cp0_reg_we / wb_cp0_reg_write_addr / wb_cp0_reg_data).
- Holds Count, Compare, Status, Cause, EPC, PRId and Config.
- Free-running Count timer with sticky timer interrupt.
- Asynchronous read port serves mfc0 in EX; samples hardware interrupt lines into Cause.IP.

---
 rtl/cp0_reg_if.sv | 11 +
 rtl/cp0_reg.sv | 111 +++++++++++
 2 files changed

// File: rtl/cp0_reg_if.sv
// CP0 access bus: writeback-stage write port plus the EX-stage mfc0 read port.
interface cp0_reg_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_o;

  modport master (output we_i, output waddr_i, output data_i, output raddr_i, input data_o);
  modport slave  (input we_i, input waddr_i, input data_i, input raddr_i, output data_o);
endinterface

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC, PRId, Config.
// Optional CP0_COUNT_DIV2_EN: Count advances every other cycle.
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
  parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
  input  logic        clk,
  input  logic        rst,
  cp0_reg_if.slave    bus,
  input  logic [5:0]  int_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;
  localparam logic [4:0] ADDR_CONFIG  = 5'd16;

  // Software-writable Cause bits: IV, WP, IP[1:0]
  localparam logic [31:0] CAUSE_WMASK = 32'h00C00300;

  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        count_tick;
  logic        timer_match;
  logic [31:0] cause_next;

  assign wr_count   = bus.we_i && (bus.waddr_i == ADDR_COUNT);
  assign wr_compare = bus.we_i && (bus.waddr_i == ADDR_COMPARE);
  assign wr_status  = bus.we_i && (bus.waddr_i == ADDR_STATUS);
  assign wr_cause   = bus.we_i && (bus.waddr_i == ADDR_CAUSE);
  assign wr_epc     = bus.we_i && (bus.waddr_i == ADDR_EPC);

  assign timer_match = (compare_o != 32'd0) && (count_o == compare_o);

`ifdef CP0_COUNT_DIV2_EN
  logic count_phase;

  always_ff @(posedge clk) begin
    if (rst || wr_count) count_phase <= 1'b0;
    else                 count_phase <= ~count_phase;
  end

  assign count_tick = count_phase;
`else
  assign count_tick = 1'b1;
`endif

  always_comb begin
    cause_next        = wr_cause ? (bus.data_i & CAUSE_WMASK) : (cause_o & CAUSE_WMASK);
    cause_next[15:10] = int_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_o     <= 32'd0;
      compare_o   <= 32'd0;
      status_o    <= STATUS_RESET;
      cause_o     <= 32'd0;
      epc_o       <= 32'd0;
      timer_int_o <= 1'b0;
    end else begin
      if (wr_count)        count_o <= bus.data_i;
      else if (count_tick) count_o <= count_o + 32'd1;

      if (wr_compare) compare_o <= bus.data_i;

      // Writing Compare acknowledges the timer, even against a same-cycle match
      if (wr_compare)       timer_int_o <= 1'b0;
      else if (timer_match) timer_int_o <= 1'b1;

      if (wr_status) status_o <= bus.data_i;
      if (wr_epc)    epc_o    <= bus.data_i;
      cause_o <= cause_next;
    end
  end

  assign prid_o   = PRID_VALUE;
  assign config_o = CONFIG_VALUE;

  always_comb begin
    bus.data_o = 32'd0;
    if (!rst) begin
      case (bus.raddr_i)
        ADDR_COUNT:   bus.data_o = count_o;
        ADDR_COMPARE: bus.data_o = compare_o;
        ADDR_STATUS:  bus.data_o = status_o;
        ADDR_CAUSE:   bus.data_o = cause_o;
        ADDR_EPC:     bus.data_o = epc_o;
        ADDR_PRID:    bus.data_o = PRID_VALUE;
        ADDR_CONFIG:  bus.data_o = CONFIG_VALUE;
        default:      bus.data_o = 32'd0;
      endcase
    end
  end

endmodule
